float8_encoder: RTL

//  Sequential encoder: signed two's-complement fixed-point value -> 8-bit float (Float8) in the

---
 rtl/float8_encoder_if.sv | 20 ++
 rtl/float8_encoder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/float8_encoder_if.sv
// Valid/ready handshake bundle around float8_encoder: fixed-point value in, Float8 result out.
interface float8_encoder_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] iFix;
   logic             iValid;
   logic             oReady;
   logic [7:0]       oNum;
   logic             oOverflow;
   logic             oValid;
   logic             iReady;

   modport slave (
      input  iFix, iValid, iReady,
      output oReady, oNum, oOverflow, oValid
   );

   modport master (
      output iFix, iValid, iReady,
      input  oReady, oNum, oOverflow, oValid
   );
endinterface

// File: rtl/float8_encoder.sv
// Signed fixed-point to Float8 {sign, exp[2:0] bias 4, mant[3:0]} encoder with a
// one-bit-per-cycle normaliser between valid/ready handshakes.
//
// state | meaning
// IDLE  | oReady high, waiting for an upstream transfer
// ABS   | take the magnitude of the latched input
// NORM  | shift left until the MSB is set (or the magnitude is zero)
// PACK  | form exponent/mantissa, saturate or flush, register the result
// DONE  | result held; oValid raised, then released on iReady
module float8_encoder #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input  logic             iClk,
   input  logic             iRst_n,
   float8_encoder_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} state_t;

   state_t           state, stateNext;
   logic             sign, signNext;
   logic [WIDTH-1:0] raw, rawNext;
   logic [WIDTH-1:0] mag, magNext;
   logic [CW-1:0]    cnt, cntNext;
   logic [7:0]       numQ, numNext;
   logic             ovfQ, ovfNext;
   logic             validQ, validNext;

   int               e;
   logic [7:0]       packNum;
   logic             packOvf;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state  <= IDLE;
         sign   <= 1'b0;
         raw    <= '0;
         mag    <= '0;
         cnt    <= '0;
         numQ   <= 8'h00;
         ovfQ   <= 1'b0;
         validQ <= 1'b0;
      end else begin
         state  <= stateNext;
         sign   <= signNext;
         raw    <= rawNext;
         mag    <= magNext;
         cnt    <= cntNext;
         numQ   <= numNext;
         ovfQ   <= ovfNext;
         validQ <= validNext;
      end
   end

   // Unbiased exponent of the normalised magnitude; out-of-range values saturate or flush.
   always_comb begin
      e       = (WIDTH - 1 - int'(cnt)) - FRAC;
      packNum = 8'h00;
      packOvf = 1'b0;
      if (mag != '0) begin
         if (e > 3) begin
            packNum = {sign, 7'h7F};
            packOvf = 1'b1;
         end else if (e >= -3) begin
            packNum = {sign, 3'(e + 4), mag[WIDTH-2 -: 4]};
         end
      end
   end

   always_comb begin
      stateNext = state;
      signNext  = sign;
      rawNext   = raw;
      magNext   = mag;
      cntNext   = cnt;
      numNext   = numQ;
      ovfNext   = ovfQ;
      validNext = validQ;
      case (state)
         IDLE: begin
            if (bus.iValid) begin
               signNext  = bus.iFix[WIDTH-1];
               rawNext   = bus.iFix;
               stateNext = ABS;
            end
         end
         ABS: begin
            // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
            magNext   = raw[WIDTH-1] ? (~raw + WIDTH'(1)) : raw;
            cntNext   = '0;
            stateNext = NORM;
         end
         NORM: begin
            if (mag == '0 || mag[WIDTH-1]) begin
               stateNext = PACK;
            end else begin
               magNext = mag << 1;
               cntNext = cnt + 1'b1;
            end
         end
         PACK: begin
            numNext   = packNum;
            ovfNext   = packOvf;
            stateNext = DONE;
         end
         DONE: begin
            // oValid rises one cycle after the result registers settle.
            if (!validQ) begin
               validNext = 1'b1;
            end else if (bus.iReady) begin
               validNext = 1'b0;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.oReady    = (state == IDLE);
   assign bus.oNum      = numQ;
   assign bus.oOverflow = ovfQ;
   assign bus.oValid    = validQ;

endmodule
